// File: rtl/aes_key_reverse.sv
// Streaming inverse AES-128 key schedule: emits round keys 10..0, recomputing one word per cycle.
// Optional macro AES_EQ_INV_KEY_EN: rounds 9..1 are output through InvMixColumns (equivalent inverse cipher).
module aes_key_reverse #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] last_key_i,
  output logic [127:0] key_o,
  output logic [3:0]   round_o,
  output logic         key_valid_o,
  input  logic         key_ready_i,
  output logic         busy_o,
  output logic         done_o
);

  if (NUM_ROUNDS != 10) begin : g_rounds_check
    $error("aes_key_reverse supports only NUM_ROUNDS = 10");
  end

  typedef enum logic [1:0] {IDLE, PRESENT, COMPUTE} state_t;

  state_t       state, state_nxt;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic [1:0]   word_q;
  logic         done_q;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] a);
    sub_word = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  logic [31:0] w0, w1, w2, w3, word_new, v3_rot;

  assign {w0, w1, w2, w3} = key_q;
  // On the word-0 cycle w3 already holds the new v3, as the v0 equation requires.
  assign v3_rot = {w3[23:0], w3[31:24]};

  always_comb begin
    word_new = '0;
    case (word_q)
      2'd3:    word_new = w3 ^ w2;
      2'd2:    word_new = w2 ^ w1;
      2'd1:    word_new = w1 ^ w0;
      default: word_new = w0 ^ sub_word(v3_rot) ^ {rcon(round_q), 24'h0};
    endcase
  end

  always_comb begin
    state_nxt   = state;
    key_valid_o = 1'b0;
    busy_o      = (state != IDLE);
    case (state)
      IDLE: if (start_i) state_nxt = PRESENT;
      PRESENT: begin
        key_valid_o = 1'b1;
        if (key_ready_i) state_nxt = (round_q == 4'd0) ? IDLE : COMPUTE;
      end
      COMPUTE: if (word_q == 2'd0) state_nxt = PRESENT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == PRESENT) && key_ready_i && (round_q == 4'd0);
      case (state)
        IDLE: begin
          if (start_i) begin
            key_q   <= last_key_i;
            round_q <= 4'd10;
          end
        end
        PRESENT: begin
          if (key_ready_i && round_q != 4'd0) word_q <= 2'd3;
        end
        COMPUTE: begin
          case (word_q)
            2'd3:    key_q[31:0]   <= word_new;
            2'd2:    key_q[63:32]  <= word_new;
            2'd1:    key_q[95:64]  <= word_new;
            default: key_q[127:96] <= word_new;
          endcase
          word_q <= word_q - 2'd1;
          if (word_q == 2'd0) round_q <= round_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign round_o = round_q;
  assign done_o  = done_q;

`ifdef AES_EQ_INV_KEY_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    gm = (c[0] ? b : 8'h00) ^ (c[1] ? b2 : 8'h00) ^ (c[2] ? b4 : 8'h00) ^ (c[3] ? b8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    inv_mix_col = {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
                   gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
                   gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
                   gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
  endfunction

  // Schedule stays raw; only the presented key is transformed, and never for rounds 10 and 0.
  assign key_o = (round_q != 4'd0 && round_q != 4'd10)
               ? {inv_mix_col(w0), inv_mix_col(w1), inv_mix_col(w2), inv_mix_col(w3)}
               : key_q;
`else
  assign key_o = key_q;
`endif

endmodule
